rv_sim_memory: RTL

Parametrised, synthesizable unified instruction/data memory model for rv32e_cpu benches and FPGA bring-up. It replaces ad-hoc per-bench instruction stubs with one word-organised array that has three ports: an instruction read port, a data read/write port with byte enables, and a preload port. Each CPU-facing port has a programmable wait-state count and a request/ready handshake, so stall and flush paths can be exercised.

---
 rtl/rv_sim_memory.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_sim_memory.sv
// rv_sim_memory: unified instruction/data memory model for rv32e_cpu benches and FPGA bring-up.
// One word-organised array with a fetch port, a byte-enabled data port and a preload port.
// Each CPU port runs an IDLE/WAIT handshake with a programmable wait-state count.
module rv_sim_memory #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned IMEM_LAT  = 0,
  parameter int unsigned DMEM_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  // Instruction port
  input  logic                 imem_read,
  input  logic [31:0]          imem_addr,
  output logic [DATA_W-1:0]    imem_data,
  output logic                 imem_ready,
  output logic                 imem_err,
  // Data port
  input  logic                 dmem_read,
  input  logic                 dmem_write,
  input  logic [31:0]          dmem_addr,
  input  logic [DATA_W-1:0]    dmem_wdata,
  input  logic [3:0]           dmem_byte_enable,
  output logic [DATA_W-1:0]    dmem_rdata,
  output logic                 dmem_ready,
  output logic                 dmem_err,
  // Preload port
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_W-1:0]    load_data
);

  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam logic [3:0]  ImemLat = 4'(IMEM_LAT);
  localparam logic [3:0]  DmemLat = 4'(DMEM_LAT);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } port_state_e;

  // Storage is deliberately left out of reset so preloaded images survive a CPU reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Any set bit above the word index means the byte address is at or beyond 4*DEPTH.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return addr[31:ADDR_BITS+2] == '0;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Instruction port
  // ---------------------------------------------------------------------------------------------
  port_state_e          i_state_q, i_state_d;
  logic [3:0]           i_cnt_q, i_cnt_d;
  logic [31:0]          i_addr_q;
  logic                 i_accept;
  logic                 i_done;
  logic                 i_fault;
  logic [ADDR_BITS-1:0] i_idx;

  assign i_idx   = i_addr_q[ADDR_BITS+1:2];
  assign i_fault = (i_addr_q[1:0] != 2'b00) || !addr_in_range(i_addr_q);

  // Fetch FSM next state: accept in IDLE, count down in WAIT, complete when the counter is 0.
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_accept  = 1'b0;
    i_done    = 1'b0;
    unique case (i_state_q)
      StIdle: begin
        if (imem_read) begin
          i_accept  = 1'b1;
          i_cnt_d   = ImemLat;
          i_state_d = StWait;
        end
      end
      StWait: begin
        if (i_cnt_q == 4'd0) begin
          i_done    = 1'b1;
          i_state_d = StIdle;
        end else begin
          i_cnt_d = i_cnt_q - 4'd1;
        end
      end
      default: i_state_d = StIdle;
    endcase
  end

  // Fetch state, captured address and registered outputs; data holds until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state_q  <= StIdle;
      i_cnt_q    <= 4'd0;
      i_addr_q   <= 32'd0;
      imem_ready <= 1'b0;
      imem_err   <= 1'b0;
      imem_data  <= '0;
    end else begin
      i_state_q  <= i_state_d;
      i_cnt_q    <= i_cnt_d;
      if (i_accept) begin
        i_addr_q <= imem_addr;
      end
      imem_ready <= i_done;
      imem_err   <= i_done && i_fault;
      if (i_done) begin
        imem_data <= i_fault ? '0 : mem[i_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------------------------------
  port_state_e          d_state_q, d_state_d;
  logic [3:0]           d_cnt_q, d_cnt_d;
  logic [31:2]          d_addr_q;
  logic [DATA_W-1:0]    d_wdata_q;
  logic [3:0]           d_be_q;
  logic                 d_write_q;
  logic                 d_accept;
  logic                 d_done;
  logic                 d_in_range;
  logic                 d_commit;
  logic [ADDR_BITS-1:0] d_idx;

  // Sub-word offsets carry no meaning here; lanes are chosen by byte_enable alone.
  logic unused_dmem_lsb;
  assign unused_dmem_lsb = ^dmem_addr[1:0];

  assign d_idx      = d_addr_q[ADDR_BITS+1:2];
  assign d_in_range = addr_in_range({d_addr_q, 2'b00});
  // Reset gating guards against an edge that coincides with reset assertion.
  assign d_commit   = d_done && d_write_q && d_in_range && !reset;

  // Data FSM next state: same handshake as the fetch port, with read or write as the request.
  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_accept  = 1'b0;
    d_done    = 1'b0;
    unique case (d_state_q)
      StIdle: begin
        if (dmem_read || dmem_write) begin
          d_accept  = 1'b1;
          d_cnt_d   = DmemLat;
          d_state_d = StWait;
        end
      end
      StWait: begin
        if (d_cnt_q == 4'd0) begin
          d_done    = 1'b1;
          d_state_d = StIdle;
        end else begin
          d_cnt_d = d_cnt_q - 4'd1;
        end
      end
      default: d_state_d = StIdle;
    endcase
  end

  // Data state, captured request and registered outputs; a write never disturbs dmem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state_q  <= StIdle;
      d_cnt_q    <= 4'd0;
      d_addr_q   <= 30'd0;
      d_wdata_q  <= '0;
      d_be_q     <= 4'd0;
      d_write_q  <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      if (d_accept) begin
        d_addr_q  <= dmem_addr[31:2];
        d_wdata_q <= dmem_wdata;
        d_be_q    <= dmem_byte_enable;
        d_write_q <= dmem_write;
      end
      dmem_ready <= d_done;
      dmem_err   <= d_done && !d_in_range;
      if (d_done && !d_write_q) begin
        dmem_rdata <= d_in_range ? mem[d_idx] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Array write: byte-lane data writes, then the loader, so a same-word load wins outright.
  // Reads elsewhere sample the pre-edge contents, giving read-before-write on collisions.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (d_commit && d_be_q[lane]) begin
        mem[d_idx][8*lane +: 8] <= d_wdata_q[8*lane +: 8];
      end
    end
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule
